// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/icache_pkg.sv
// Types and width helpers for the direct-mapped one-word instruction cache.
package icache_pkg;
    import cpu_types_pkg::word_t;

    localparam int ADDR_W    = 32;
    localparam int TAG_MAX_W = 30;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Tag is stored at its widest possible size; unused upper bits stay zero.
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        word_t                data;
    } icache_frame_t;

    function automatic int idx_width(int nsets);
        return $clog2(nsets);
    endfunction

    function automatic int tag_width(int nsets);
        return ADDR_W - 2 - $clog2(nsets);
    endfunction
endpackage

// File: rtl/icache_if.sv
// Datapath<->cache and cache<->memory buses; master is the requesting side.
interface dp_cache_if;
    import cpu_types_pkg::*;
    logic  dp_imemREN;
    word_t dp_imemaddr;
    logic  dp_flush;
    logic  dp_ihit;
    word_t dp_imemload;

    modport master (output dp_imemREN, dp_imemaddr, dp_flush,
                    input  dp_ihit, dp_imemload);
    modport slave  (input  dp_imemREN, dp_imemaddr, dp_flush,
                    output dp_ihit, dp_imemload);
endinterface

interface cache_mem_if;
    import cpu_types_pkg::*;
    logic  mem_iREN;
    word_t mem_iaddr;
    word_t mem_iload;
    logic  mem_iwait;

    modport master (output mem_iREN, mem_iaddr,
                    input  mem_iload, mem_iwait);
    modport slave  (input  mem_iREN, mem_iaddr,
                    output mem_iload, mem_iwait);
endinterface

// File: rtl/icache_frames.sv
// Frame storage: one write port, one combinational read port, bulk valid clear.
module icache_frames
    import icache_pkg::*;
#(
    parameter int NSETS = 16,
    parameter int IDX_W = idx_width(NSETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  icache_frame_t    wframe_i,
    input  logic [IDX_W-1:0] ridx_i,
    output icache_frame_t    rframe_o
);
    icache_frame_t frames_q [NSETS];

    // Clearing wins over a same-edge write so a flushed fill never lands.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            for (int i = 0; i < NSETS; i++) begin
                frames_q[i].valid <= 1'b0;
            end
        end else if (we_i) begin
            frames_q[widx_i] <= wframe_i;
        end
    end

    assign rframe_o = frames_q[ridx_i];
endmodule

// File: rtl/icache.sv
// Direct-mapped one-word instruction cache with IDLE/FILL miss handling.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
    import cpu_types_pkg::*, icache_pkg::*;
#(
    parameter int NSETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    dp_cache_if.slave   dp,
    cache_mem_if.master mem
`ifdef ICACHE_STATS_EN
    ,
    output word_t       hit_count,
    output word_t       miss_count
`endif
);
    localparam int IDX_W = idx_width(NSETS);

    icache_state_t        state_q, state_d;
    word_t                miss_addr_q, miss_addr_d;
    icache_frame_t        rframe, wframe;
    logic                 hit, fill_we;
    logic [TAG_MAX_W-1:0] req_tag, miss_tag;
    logic                 unused_byte_off;

    assign req_tag         = TAG_MAX_W'(dp.dp_imemaddr[ADDR_W-1:IDX_W+2]);
    assign miss_tag        = TAG_MAX_W'(miss_addr_q[ADDR_W-1:IDX_W+2]);
    assign unused_byte_off = ^dp.dp_imemaddr[1:0];
    assign wframe          = '{valid: 1'b1, tag: miss_tag, data: mem.mem_iload};

    icache_frames #(.NSETS(NSETS)) u_frames (
        .clk      (CLK),
        .rst      (RST),
        .clear_i  (dp.dp_flush),
        .we_i     (fill_we),
        .widx_i   (miss_addr_q[IDX_W+1:2]),
        .wframe_i (wframe),
        .ridx_i   (dp.dp_imemaddr[IDX_W+1:2]),
        .rframe_o (rframe)
    );

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        fill_we     = 1'b0;
        hit         = 1'b0;
        unique case (state_q)
            IDLE: begin
                hit = dp.dp_imemREN && !dp.dp_flush && rframe.valid
                      && (rframe.tag == req_tag);
                if (dp.dp_imemREN && !hit && !dp.dp_flush) begin
                    state_d     = FILL;
                    miss_addr_d = {dp.dp_imemaddr[ADDR_W-1:2], 2'b00};
                end
            end
            FILL: begin
                // A flush abandons the fill; the returning word is dropped.
                if (dp.dp_flush) begin
                    state_d = IDLE;
                end else if (!mem.mem_iwait) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    assign dp.dp_ihit     = hit;
    assign dp.dp_imemload = hit ? rframe.data : '0;
    assign mem.mem_iREN   = (state_q == FILL);
    assign mem.mem_iaddr  = (state_q == FILL) ? miss_addr_q : '0;

`ifdef ICACHE_STATS_EN
    word_t hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if ((state_q == IDLE) && (state_d == FILL) && (miss_count_q != '1)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule
